// File: rtl/pulse_stretch_pkg.sv
// rtl/pulse_stretch_pkg.sv - shared types and defaults for the pulse stretcher
// Purpose: FSM state encoding and default CNT_W / HOLDOFF values used by
//          pulse_stretch and its down-counter.
// Ports:   none (package).
package pulse_stretch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_STRETCH = 2'd1,
    ST_HOLDOFF = 2'd2
  } state_t;

  localparam int CNT_W_DEF   = 16;
  localparam int HOLDOFF_DEF = 4;

endpackage

// File: rtl/ps_down_cnt.sv
// rtl/ps_down_cnt.sv - loadable down-counter with zero flag
// Purpose: CNT_W-bit counter that loads a value, decrements on request and
//          saturates at zero (never wraps).
// Ports:   clk, reset (async, active-high), load/load_val (load has priority),
//          dec (decrement request), zero (count == 0).
module ps_down_cnt
  import pulse_stretch_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - CNT_W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/pulse_stretch.sv
// rtl/pulse_stretch.sv - trigger-to-level pulse stretcher with holdoff
// Purpose: a trigger with nonzero len drives out high for exactly len cycles,
//          then a HOLDOFF-cycle dead time during which triggers are dropped.
//          Optional macro RETRIGGER_EN: a trigger during the stretch reloads
//          the length instead of being dropped.
// Ports:   clk, reset (async, active-high), pulse_in (trigger), len (length,
//          sampled on accepted trigger), out (stretched level), busy (not
//          idle), done (1-cycle pulse at stretch end), drop (1-cycle pulse
//          for an ignored trigger). All outputs are registered.
module pulse_stretch
  import pulse_stretch_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEF,
  parameter int HOLDOFF = HOLDOFF_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pulse_in,
  input  logic [CNT_W-1:0] len,
  output logic             out,
  output logic             busy,
  output logic             done,
  output logic             drop
);

  // Counter value that yields exactly HOLDOFF cycles in ST_HOLDOFF.
  localparam logic [CNT_W-1:0] HOLD_LOAD = (HOLDOFF > 0) ? CNT_W'(HOLDOFF - 1) : '0;

  state_t           state, state_next;
  logic             cnt_load, cnt_dec, cnt_zero;
  logic [CNT_W-1:0] cnt_val;
  logic             trig_ok;
  logic             out_next, busy_next, done_next, drop_next;

  assign trig_ok = pulse_in && (len != '0);

  ps_down_cnt #(.CNT_W(CNT_W)) u_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (cnt_val),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      out   <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      drop  <= 1'b0;
    end else begin
      state <= state_next;
      out   <= out_next;
      busy  <= busy_next;
      done  <= done_next;
      drop  <= drop_next;
    end
  end

  // Next state and counter control. The counter holds len-1 on entry so the
  // stretch covers len cycles including the zero-count cycle.
  always_comb begin
    state_next = state;
    cnt_load   = 1'b0;
    cnt_val    = '0;
    cnt_dec    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (trig_ok) begin
          state_next = ST_STRETCH;
          cnt_load   = 1'b1;
          cnt_val    = len - CNT_W'(1);
        end
      end
      ST_STRETCH: begin
`ifdef RETRIGGER_EN
        // Reload beats the end-of-stretch exit in the same cycle.
        if (trig_ok) begin
          cnt_load = 1'b1;
          cnt_val  = len - CNT_W'(1);
        end else
`endif
        if (cnt_zero) begin
          if (HOLDOFF > 0) begin
            state_next = ST_HOLDOFF;
            cnt_load   = 1'b1;
            cnt_val    = HOLD_LOAD;
          end else begin
            state_next = ST_IDLE;
          end
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_HOLDOFF: begin
        if (cnt_zero) begin
          state_next = ST_IDLE;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Registered-output next values.
  always_comb begin
    out_next  = (state_next == ST_STRETCH);
    busy_next = (state_next != ST_IDLE);
    done_next = (state == ST_STRETCH) && (state_next != ST_STRETCH);
    drop_next = 1'b0;
    case (state)
      ST_IDLE:    drop_next = pulse_in && (len == '0);
`ifdef RETRIGGER_EN
      ST_STRETCH: drop_next = pulse_in && (len == '0);
`else
      ST_STRETCH: drop_next = pulse_in;
`endif
      ST_HOLDOFF: drop_next = pulse_in;
      default:    drop_next = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_pulse_stretch.sv
// tb/tb_pulse_stretch.sv - scoreboard bench for pulse_stretch
// Purpose: drives two instances (HOLDOFF=4 / CNT_W=6 and HOLDOFF=0 / CNT_W=4)
//          with directed and random triggers; expected outputs come from a
//          remaining-cycles model and are checked by a separate monitor.
// Ports:   none (top-level bench).
module tb_pulse_stretch;

  typedef struct packed {
    logic out;
    logic busy;
    logic done;
    logic drop;
  } obs_t;

`ifdef RETRIGGER_EN
  localparam bit RETRIG = 1'b1;
`else
  localparam bit RETRIG = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       pa, pb;
  logic [5:0] la;
  logic [3:0] lb;
  logic       out_a, busy_a, done_a, drop_a;
  logic       out_b, busy_b, done_b, drop_b;

  int   total = 0;
  int   bad   = 0;
  bit   chk_en = 1'b0;
  obs_t qa[$];
  obs_t qb[$];
  int   hi_a, ho_a, hi_b, ho_b;

  always #5 clk = ~clk;

  pulse_stretch #(.CNT_W(6), .HOLDOFF(4)) u_dut_a (
    .clk(clk), .reset(reset), .pulse_in(pa), .len(la),
    .out(out_a), .busy(busy_a), .done(done_a), .drop(drop_a)
  );

  pulse_stretch #(.CNT_W(4), .HOLDOFF(0)) u_dut_b (
    .clk(clk), .reset(reset), .pulse_in(pb), .len(lb),
    .out(out_b), .busy(busy_b), .done(done_b), .drop(drop_b)
  );

  // hi = high cycles still owed, ho = dead cycles still owed.
  function automatic void model_step(input int holdoff, inout int hi, inout int ho,
                                     input logic p, input int l, output obs_t o);
    o.done = 1'b0;
    o.drop = 1'b0;
    if (hi > 0) begin
      if (p && RETRIG && (l != 0)) begin
        hi = l;
      end else begin
        if (p) o.drop = 1'b1;
        hi = hi - 1;
        if (hi == 0) begin
          o.done = 1'b1;
          ho = holdoff;
        end
      end
    end else if (ho > 0) begin
      if (p) o.drop = 1'b1;
      ho = ho - 1;
    end else begin
      if (p && (l != 0)) hi = l;
      else if (p) o.drop = 1'b1;
    end
    o.out  = (hi > 0);
    o.busy = (hi > 0) || (ho > 0);
  endfunction

  task automatic check(input string nm, input logic [3:0] got, input logic [3:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s t=%0t got=%b exp=%b", nm, $time, got, exp);
    end
  endtask

  // Drive inputs for the coming edge, predict, then advance one cycle.
  task automatic step(input logic a_p, input int a_l, input logic b_p, input int b_l);
    obs_t ea, eb;
    pa = a_p;
    la = a_l[5:0];
    pb = b_p;
    lb = b_l[3:0];
    model_step(4, hi_a, ho_a, a_p, a_l, ea);
    model_step(0, hi_b, ho_b, b_p, b_l, eb);
    qa.push_back(ea);
    qb.push_back(eb);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 0, 1'b0, 0);
  endtask

  // Monitor: every cycle both DUTs present outputs; pop and compare.
  initial begin
    obs_t e;
    forever begin
      @(posedge clk);
      #1;
      if (chk_en) begin
        total++;
        if (qa.size() == 0) begin
          bad++;
          $display("FAIL sb_a_underflow t=%0t", $time);
        end else begin
          e = qa.pop_front();
          if ({out_a, busy_a, done_a, drop_a} !== e) begin
            bad++;
            $display("FAIL dut_a t=%0t got=%b exp=%b", $time,
                     {out_a, busy_a, done_a, drop_a}, e);
          end
        end
        total++;
        if (qb.size() == 0) begin
          bad++;
          $display("FAIL sb_b_underflow t=%0t", $time);
        end else begin
          e = qb.pop_front();
          if ({out_b, busy_b, done_b, drop_b} !== e) begin
            bad++;
            $display("FAIL dut_b t=%0t got=%b exp=%b", $time,
                     {out_b, busy_b, done_b, drop_b}, e);
          end
        end
      end
    end
  end

  initial begin
    reset = 1'b1;
    pa = 1'b0; la = '0; pb = 1'b0; lb = '0;
    hi_a = 0; ho_a = 0; hi_b = 0; ho_b = 0;
    #3;
    check("reset_a", {out_a, busy_a, done_a, drop_a}, 4'b0000);
    check("reset_b", {out_b, busy_b, done_b, drop_b}, 4'b0000);
    @(negedge clk);
    reset = 1'b0;
    chk_en = 1'b1;

    // Single trigger len=5; zero-length trigger.
    step(1'b1, 5, 1'b1, 5);
    idle(12);
    step(1'b1, 0, 1'b1, 0);
    idle(3);

    // Second trigger three cycles into a len=8 stretch.
    step(1'b1, 8, 1'b1, 8);
    idle(2);
    step(1'b1, 8, 1'b1, 8);
    idle(16);

    // Triggers in holdoff (dropped) and just after it (accepted).
    step(1'b1, 2, 1'b0, 0);
    idle(4);
    step(1'b1, 3, 1'b0, 0);
    idle(3);
    step(1'b1, 3, 1'b0, 0);
    idle(10);

    // Maximum length on each instance.
    step(1'b1, 63, 1'b1, 15);
    idle(70);

    // Continuously high trigger, len=3, on the zero-holdoff instance.
    for (int i = 0; i < 20; i++) step(1'b0, 0, 1'b1, 3);
    idle(6);

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(0, 3) == 0, $urandom_range(0, 12),
           $urandom_range(0, 2) == 0, $urandom_range(0, 5));
    end
    idle(20);

    // Asynchronous reset in the middle of a len=10 stretch.
    step(1'b1, 10, 1'b1, 10);
    idle(3);
    check("pre_reset_a", {out_a, busy_a, done_a, drop_a}, 4'b1100);
    chk_en = 1'b0;
    reset  = 1'b1;
    #2;
    check("async_reset_a", {out_a, busy_a, done_a, drop_a}, 4'b0000);
    check("async_reset_b", {out_b, busy_b, done_b, drop_b}, 4'b0000);
    @(negedge clk);
    reset = 1'b0;
    hi_a = 0; ho_a = 0; hi_b = 0; ho_b = 0;
    qa.delete();
    qb.delete();
    chk_en = 1'b1;
    step(1'b1, 10, 1'b1, 10);
    idle(16);

    chk_en = 1'b0;
    check("sb_a_drained", 4'(qa.size()), 4'd0);
    check("sb_b_drained", 4'(qb.size()), 4'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pulse_stretch.md
PULSE_STRETCH -- requirements
Module: pulse_stretch

Interface
REQ-001 SHALL have parameter: CNT_W, 16, width of length counter and len port.
REQ-002 SHALL have parameter: HOLDOFF, 4, cycles of dead time after each stretched output; 0 legal.
REQ-003 SHALL have port: clk  input  1  rising-edge clock.
REQ-004 SHALL have port: reset  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port: pulse_in  input  1  trigger, sampled each clk; any high cycle is a trigger.
REQ-006 SHALL have port: len  input  CNT_W  stretch length in cycles, sampled only on an accepted trigger.
REQ-007 SHALL have port: out  output  1  stretched level.
REQ-008 SHALL have port: busy  output  1  high in STRETCH or HOLDOFF.
REQ-009 SHALL have port: done  output  1  one-cycle pulse when a stretch ends.
REQ-010 SHALL have port: drop  output  1  one-cycle pulse when a trigger is ignored.

Function
REQ-011 SHALL implement FSM states IDLE, STRETCH, HOLDOFF; all outputs registered.
REQ-012 IDLE + pulse_in + len!=0 SHALL go to STRETCH, load counter with len-1; out rises the next cycle (latency 1).
REQ-013 IDLE + pulse_in + len==0 SHALL stay IDLE, out stays 0, drop pulses next cycle.
REQ-014 In STRETCH, out SHALL be 1 and the counter SHALL decrement by 1 per cycle; out high exactly len cycles per untouched trigger.
REQ-015 STRETCH with counter==0 SHALL exit to HOLDOFF (counter loaded HOLDOFF-1) if HOLDOFF>0, else IDLE.
REQ-016 done SHALL pulse high for one cycle, coinciding with the first cycle out is 0 after a stretch.
REQ-017 HOLDOFF SHALL last exactly HOLDOFF cycles, out=0, then go to IDLE; counter down-counts with no wrap.
REQ-018 pulse_in in HOLDOFF SHALL be ignored, drop pulses next cycle.
REQ-019 pulse_in in STRETCH SHALL follow REQ-025/REQ-026.
REQ-020 busy SHALL equal (state!=IDLE), registered alongside out.
REQ-021 Continuous-high pulse_in SHALL be treated per cycle: accepted in IDLE, then handled per state rules; no edge detection internal.
REQ-022 Counter arithmetic SHALL be unsigned CNT_W; len==2^CNT_W-1 SHALL give 2^CNT_W-1 high cycles.

Reset
REQ-023 reset SHALL force state IDLE, counter 0, out=0, busy=0, done=0, drop=0 immediately, including mid-STRETCH or mid-HOLDOFF.
REQ-024 First trigger SHALL be accepted on the first rising clk after reset deasserts.

Configuration
REQ-025 With RETRIGGER_EN defined, pulse_in in STRETCH with len!=0 SHALL reload counter with len-1 (out stays high, no done); reload wins over end-of-stretch in the same cycle; len==0 there SHALL drop.
REQ-026 Without RETRIGGER_EN, pulse_in in STRETCH SHALL be ignored and drop pulses next cycle; stretch length unchanged.

Structure
REQ-027 Shared package pulse_stretch_pkg SHALL hold the state enum and default CNT_W/HOLDOFF constants.
REQ-028 One sub-module SHALL be natural: ps_down_cnt, loadable CNT_W down-counter with zero flag; FSM stays in pulse_stretch.
REQ-029 Implementation SHALL be synthesizable, single clock domain, no latches.

Verification
REQ-030 len=5, one-cycle pulse_in in IDLE -> out high exactly 5 cycles starting 1 cycle later; done on cycle 7; busy high 5+4 cycles.
REQ-031 len=0 pulse in IDLE -> out stays 0, drop pulses once, busy stays 0.
REQ-032 len=8, second pulse 3 cycles into STRETCH -> without RETRIGGER_EN: 8 high cycles, drop once; with: 3+8=11 high cycles, one done.
REQ-033 HOLDOFF=4, pulse 2 cycles after done -> drop pulses, out stays 0; pulse 5 cycles after done -> accepted.
REQ-034 reset asserted mid-STRETCH (len=10, cycle 4) -> out, busy drop to 0 without clk edge; next pulse after release gives full 10-cycle stretch.
REQ-035 HOLDOFF=0, pulse_in held high 20 cycles, len=3, no RETRIGGER_EN -> out pattern 3 high/1 low repeating, done every 4 cycles, drop during each high period.
